// File: rtl/data_mem_bridge_if.sv
// Data-memory bus between the load/store bridge (master) and the memory (slave).
// A request is presented with bus_req and stays stable until bus_ack; read data returns with the ack.
interface data_mem_bridge_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/data_mem_bridge.sv
// RV32I load/store bridge: turns a core data request into one req/ack bus transaction,
// handling byte enables, store lane replication, load alignment/extension and bus timeouts.
module data_mem_bridge #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [31:0]       Addr,
    input  logic [31:0]       WriteData,
    input  logic [1:0]        Load_size,
    input  logic              LoadUnsigned,
    output logic [31:0]       ReadData,
    output logic              Stall,
    output logic              Misalign,
    output logic              BusErr,
    data_mem_bridge_if.master bus
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             we_q, uns_q;
    logic [1:0]       size_q, off_q;
    logic [29:0]      word_q;
    logic [3:0]       be_q;
    logic [31:0]      wdata_q;
    logic [31:0]      rdata_q;
    logic             buserr_q;

    logic             req_c, misalign_c, accept_c, timeout_c;
    logic [3:0]       be_c;
    logic [31:0]      wdata_c, shifted_c, load_c;

    // Request decode: byte enables, replicated store data and alignment check
    always_comb begin
        be_c       = 4'b0001;
        wdata_c    = {4{WriteData[7:0]}};
        misalign_c = 1'b0;
        case (Load_size)
            2'd0: begin
                be_c       = 4'b1111;
                wdata_c    = WriteData;
                misalign_c = (Addr[1:0] != 2'b00);
            end
            2'd1: begin
                be_c       = Addr[1] ? 4'b1100 : 4'b0011;
                wdata_c    = {2{WriteData[15:0]}};
                misalign_c = Addr[0];
            end
            default: be_c = 4'(4'b0001 << Addr[1:0]);
        endcase
    end

    // Load alignment and extension from the latched offset/size
    always_comb begin
        shifted_c = bus.bus_rdata >> {off_q, 3'b000};
        case (size_q)
            2'd0:    load_c = bus.bus_rdata;
            2'd1:    load_c = {{16{~uns_q & shifted_c[15]}}, shifted_c[15:0]};
            default: load_c = {{24{~uns_q & shifted_c[7]}}, shifted_c[7:0]};
        endcase
    end

    assign req_c     = MemRead | MemWrite;
    assign accept_c  = (state == IDLE) && !Reset && req_c && !misalign_c;
    assign timeout_c = (state == REQ) && !bus.bus_ack && (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state    <= IDLE;
            cnt      <= '0;
            we_q     <= 1'b0;
            uns_q    <= 1'b0;
            size_q   <= 2'd0;
            off_q    <= 2'd0;
            word_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            buserr_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            buserr_q <= timeout_c;
            rdata_q  <= ((state == REQ) && bus.bus_ack && !we_q) ? load_c : 32'd0;
            cnt      <= ((state == REQ) && !bus.bus_ack) ? cnt + CNT_W'(1) : '0;
            if (accept_c) begin
                we_q    <= MemWrite;
                uns_q   <= LoadUnsigned;
                size_q  <= Load_size;
                off_q   <= Addr[1:0];
                word_q  <= Addr[31:2];
                be_q    <= be_c;
                wdata_q <= wdata_c;
            end
        end
    end

    // Next state plus the combinational core handshake (Stall, Misalign)
    always_comb begin
        state_nxt = state;
        Stall     = 1'b0;
        Misalign  = 1'b0;
        case (state)
            IDLE: begin
                if (!Reset && req_c) begin
                    if (misalign_c) begin
                        Misalign = 1'b1;
                    end else begin
                        Stall     = 1'b1;
                        state_nxt = REQ;
                    end
                end
            end
            REQ: begin
                Stall = 1'b1;
                if (bus.bus_ack)    state_nxt = DONE;
                else if (timeout_c) state_nxt = ERR;
            end
            DONE:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign ReadData      = rdata_q;
    assign BusErr        = buserr_q;
    assign bus.bus_req   = (state == REQ);
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = {word_q, 2'b00};
    assign bus.bus_be    = be_q;
    assign bus.bus_wdata = wdata_q;

endmodule

// File: tb/tb_data_mem_bridge.sv
// Scoreboard bench for data_mem_bridge: a byte-level reference memory predicts each access,
// a word-level bus memory answers requests, and a monitor checks everything the DUT presents.
`timescale 1ns/1ps
module tb_data_mem_bridge;

    localparam int unsigned TIMEOUT = 16;
    localparam int K_ACC = 0;
    localparam int K_MIS = 1;
    localparam int K_TMO = 2;

    typedef struct {
        int          kind;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] Addr = 32'd0;
    logic [31:0] WriteData = 32'd0;
    logic [1:0]  Load_size = 2'd0;
    logic        LoadUnsigned = 1'b0;
    logic [31:0] ReadData;
    logic        Stall, Misalign, BusErr;

    data_mem_bridge_if bus();

    data_mem_bridge #(.TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .Reset(Reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .Addr(Addr), .WriteData(WriteData), .Load_size(Load_size),
        .LoadUnsigned(LoadUnsigned), .ReadData(ReadData), .Stall(Stall),
        .Misalign(Misalign), .BusErr(BusErr), .bus(bus)
    );

    always #5 CLK = ~CLK;

    int          vectors = 0;
    int          miscompares = 0;
    exp_t        sb[$];
    logic [7:0]  ref_mem [256];
    logic [31:0] mem_w [64];
    int          slave_delay = 0;
    bit          slave_mute = 1'b0;
    int          slave_cnt = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic exp_t pop_exp(string nm);
        exp_t e;
        e = '{kind: -1, we: 1'b0, addr: 32'd0, be: 4'd0, wdata: 32'd0, rdata: 32'd0};
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: got unexpected DUT event expected none at %0t", nm, $time);
        end else begin
            e = sb.pop_front();
        end
        return e;
    endfunction

    // Bus memory: acks after slave_delay wait cycles, fires stray acks outside requests
    initial begin
        bus.bus_ack   = 1'b0;
        bus.bus_rdata = 32'd0;
        forever begin
            @(posedge CLK);
            #1;
            if (bus.bus_req && !slave_mute) begin
                if (slave_cnt >= slave_delay) begin
                    bus.bus_ack = 1'b1;
                    if (bus.bus_we) begin
                        for (int i = 0; i < 4; i++)
                            if (bus.bus_be[i])
                                mem_w[bus.bus_addr[7:2]][8*i +: 8] = bus.bus_wdata[8*i +: 8];
                        bus.bus_rdata = $urandom;
                    end else begin
                        bus.bus_rdata = mem_w[bus.bus_addr[7:2]];
                    end
                    slave_cnt = 0;
                end else begin
                    bus.bus_ack   = 1'b0;
                    bus.bus_rdata = $urandom;
                    slave_cnt++;
                end
            end else begin
                bus.bus_ack   = (!bus.bus_req && !slave_mute) ? 1'(($urandom & 3) == 0) : 1'b0;
                bus.bus_rdata = $urandom;
                slave_cnt     = 0;
            end
        end
    end

    // Monitor: pops the scoreboard on every misalign pulse, bus handshake and bus error
    initial begin
        exp_t cur, e;
        bit   pending;
        int   run_len;
        pending = 1'b0;
        run_len = 0;
        cur = '{kind: -1, we: 1'b0, addr: 32'd0, be: 4'd0, wdata: 32'd0, rdata: 32'd0};
        forever begin
            @(negedge CLK);
            if (Reset) begin
                pending = 1'b0;
                run_len = 0;
            end else begin
                if (pending) begin
                    chk("done_readdata", ReadData, cur.rdata);
                    chk("done_stall", 32'(Stall), 32'd0);
                    chk("done_bus_req", 32'(bus.bus_req), 32'd0);
                    pending = 1'b0;
                end
                if (Misalign) begin
                    e = pop_exp("misalign");
                    chk("misalign_kind", 32'(e.kind), 32'(K_MIS));
                    chk("misalign_stall", 32'(Stall), 32'd0);
                    chk("misalign_bus_req", 32'(bus.bus_req), 32'd0);
                end
                if (bus.bus_req && bus.bus_ack) begin
                    e = pop_exp("handshake");
                    chk("hs_kind", 32'(e.kind), 32'(K_ACC));
                    chk("hs_we", 32'(bus.bus_we), 32'(e.we));
                    chk("hs_addr", bus.bus_addr, e.addr);
                    chk("hs_be", 32'(bus.bus_be), 32'(e.be));
                    if (e.we) chk("hs_wdata", bus.bus_wdata, e.wdata);
                    cur = e;
                    pending = 1'b1;
                end
                if (BusErr) begin
                    e = pop_exp("buserr");
                    chk("err_kind", 32'(e.kind), 32'(K_TMO));
                    chk("err_readdata", ReadData, 32'd0);
                    chk("err_stall", 32'(Stall), 32'd0);
                    chk("err_req_cycles", 32'(run_len), 32'(TIMEOUT));
                end
                run_len = bus.bus_req ? run_len + 1 : 0;
            end
        end
    end

    // Issue one core access, predict its outcome from the byte-level reference memory
    task automatic access(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] wd,
                          input logic [1:0] sz, input bit uns, input int dly, input bit mute);
        exp_t        e;
        int          n, stalls, exp_stalls;
        bit          done;
        logic [31:0] v;
        n = (sz == 2'd0) ? 4 : (sz == 2'd1) ? 2 : 1;
        e = '{kind: K_ACC, we: wr, addr: {a[31:2], 2'b00}, be: 4'd0, wdata: 32'd0, rdata: 32'd0};
        if ((int'(a[1:0]) % n) != 0) begin
            e.kind = K_MIS;
            exp_stalls = 0;
        end else if (mute) begin
            e.kind = K_TMO;
            exp_stalls = TIMEOUT + 1;
        end else begin
            exp_stalls = dly + 2;
            for (int i = 0; i < n; i++) e.be[(int'(a[1:0]) + i) % 4] = 1'b1;
            if (wr) begin
                for (int j = 0; j < 4; j++) e.wdata[8*j +: 8] = wd[8*(j % n) +: 8];
                for (int i = 0; i < n; i++) ref_mem[int'(a[7:0]) + i] = wd[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < n; i++) v = v | (32'(ref_mem[int'(a[7:0]) + i]) << (8*i));
                if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
                e.rdata = v;
            end
        end
        sb.push_back(e);
        slave_delay = dly;
        slave_mute  = mute;
        @(posedge CLK);
        #1;
        MemWrite = wr; MemRead = rd; Addr = a; WriteData = wd;
        Load_size = sz; LoadUnsigned = uns;
        stalls = 0;
        done = 1'b0;
        for (int c = 0; c < int'(TIMEOUT) + 8; c++) begin
            @(negedge CLK);
            if (!Stall) begin
                done = 1'b1;
                break;
            end
            stalls++;
        end
        if (!done) chk("stall_release", 32'd1, 32'd0);
        chk("stall_cycles", 32'(stalls), 32'(exp_stalls));
        @(posedge CLK);
        #1;
        MemWrite = 1'b0; MemRead = 1'b0;
        slave_mute = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge CLK);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish by 500us");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          wr, rd, uns, mute;
        logic [1:0]  sz;
        logic [31:0] a;
        for (int w = 0; w < 64; w++) begin
            mem_w[w] = (w == 0) ? 32'h80FF1234 : $urandom;
            for (int b = 0; b < 4; b++) ref_mem[4*w + b] = mem_w[w][8*b +: 8];
        end

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_stall", 32'(Stall), 32'd0);
        chk("rst_bus_req", 32'(bus.bus_req), 32'd0);
        chk("rst_readdata", ReadData, 32'd0);
        chk("rst_misalign", 32'(Misalign), 32'd0);
        chk("rst_buserr", 32'(BusErr), 32'd0);
        @(posedge CLK);
        #1 Reset = 1'b0;

        access(1'b0, 1'b1, 32'h103, 32'd0, 2'd2, 1'b0, 0, 1'b0);        // LB  -> FFFFFF80
        access(1'b0, 1'b1, 32'h102, 32'd0, 2'd1, 1'b1, 0, 1'b0);        // LHU -> 000080FF
        access(1'b0, 1'b1, 32'h102, 32'd0, 2'd1, 1'b0, 0, 1'b0);        // LH  -> FFFF80FF
        access(1'b1, 1'b0, 32'h104, 32'hDEADBEEF, 2'd0, 1'b0, 1, 1'b0); // SW, 3 stall cycles
        access(1'b1, 1'b0, 32'h101, 32'h0000A5A5, 2'd1, 1'b0, 0, 1'b0); // SH misaligned
        access(1'b0, 1'b1, 32'h108, 32'd0, 2'd0, 1'b0, 0, 1'b1);        // LW timeout

        // Reset in the middle of a request abandons it
        slave_mute = 1'b1;
        @(posedge CLK);
        #1 MemRead = 1'b1; Addr = 32'h10C; Load_size = 2'd0;
        repeat (3) @(posedge CLK);
        #1 Reset = 1'b1; MemRead = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        chk("midrst_bus_req", 32'(bus.bus_req), 32'd0);
        chk("midrst_stall", 32'(Stall), 32'd0);
        chk("midrst_readdata", ReadData, 32'd0);
        @(posedge CLK);
        #1 Reset = 1'b0; slave_mute = 1'b0;
        access(1'b0, 1'b1, 32'h104, 32'd0, 2'd0, 1'b0, 0, 1'b0);        // LW -> DEADBEEF

        for (int k = 0; k < 150; k++) begin
            wr   = 1'($urandom);
            rd   = wr ? 1'($urandom) : 1'b1;
            sz   = 2'($urandom);
            uns  = 1'($urandom);
            a    = 32'h100 | 32'($urandom_range(0, 255));
            mute = !wr && ($urandom_range(0, 15) == 0);
            access(wr, rd, a, $urandom, sz, uns, $urandom_range(0, 3), mute);
        end

        repeat (5) @(posedge CLK);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
